delta_mod_encoder_mc: RTL and testbench

//  Multi-channel, parametrised successor to the single-channel delta-modulation spike encoder.

---
 rtl/delta_mod_encoder_mc.sv | 106 ++++++++++
 tb/tb_delta_mod_encoder_mc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/delta_mod_encoder_mc.sv
// Multi-channel delta-modulation spike encoder: one reconstruction register per channel,
// channel-tagged samples in, registered up/down/none spike events out on a valid/ready stream.
module delta_mod_encoder_mc #(
    parameter int DATA_W = 4,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] threshold,
    input  logic              step_mode,
    input  logic              off_spike,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              load_prev,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [DATA_W-1:0] force_prev,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [1:0]        out_spike,
    output logic [DATA_W-1:0] out_prev,
    output logic [CNT_W-1:0]  spike_cnt
);

    logic [DATA_W-1:0] prev_mem [NUM_CH];
    logic [DATA_W-1:0] prev_cur;
    logic [DATA_W-1:0] step_up;
    logic [DATA_W-1:0] step_dn;
    logic [DATA_W-1:0] next_prev;
    logic [DATA_W:0]   sum_up;
    logic              accept;
    logic              ch_ok;
    logic              load_ok;
    logic              up;
    logic              down;
    logic              emit;
    logic              collide;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign ch_ok    = int'(in_ch) < NUM_CH;
    assign load_ok  = int'(load_ch) < NUM_CH;
    assign collide  = load_prev && load_ok && (load_ch == in_ch);

    // Magnitude compares on unsigned operands avoid a signed diff while keeping the same rule.
    always_comb begin
        prev_cur  = '0;
        if (ch_ok) begin
            prev_cur = prev_mem[in_ch];
        end
        up        = (in_data > prev_cur) && ((in_data - prev_cur) >= threshold);
        down      = (in_data < prev_cur) && ((prev_cur - in_data) >= threshold);
        sum_up    = {1'b0, prev_cur} + {1'b0, threshold};
        step_up   = sum_up[DATA_W] ? '1 : sum_up[DATA_W-1:0];
        step_dn   = (prev_cur < threshold) ? '0 : (prev_cur - threshold);
        next_prev = prev_cur;
        if (up || down) begin
            if (!step_mode) begin
                next_prev = in_data;
            end else if (up) begin
                next_prev = step_up;
            end else begin
                next_prev = step_dn;
            end
        end
        emit      = accept && ch_ok && (up || down || off_spike);
    end

    // The force-load is written last so it wins over a same-edge sample update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                prev_mem[i] <= '0;
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_spike <= 2'b00;
            out_prev  <= '0;
            spike_cnt <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_ch    <= in_ch;
                out_spike <= {up, down};
                out_prev  <= collide ? force_prev : next_prev;
                if ((up || down) && (spike_cnt != '1)) begin
                    spike_cnt <= spike_cnt + CNT_W'(1);
                end
            end
            if (accept && ch_ok && (up || down)) begin
                prev_mem[in_ch] <= next_prev;
            end
            if (load_prev && load_ok) begin
                prev_mem[load_ch] <= force_prev;
            end
        end
    end

endmodule

// File: tb/tb_delta_mod_encoder_mc.sv
// Scoreboard bench for delta_mod_encoder_mc: stimulus pushes model-predicted events,
// an independent monitor pops them whenever the DUT hands an event over.
module tb_delta_mod_encoder_mc;

    localparam int DW = 4;
    localparam int NC = 4;
    localparam int CW = 4;
    localparam int CHW = 2;
    localparam int MAXV = (1 << DW) - 1;
    localparam int MAXC = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  threshold = '0;
    logic           step_mode = 1'b0;
    logic           off_spike = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [CHW-1:0] in_ch = '0;
    logic [DW-1:0]  in_data = '0;
    logic           load_prev = 1'b0;
    logic [CHW-1:0] load_ch = '0;
    logic [DW-1:0]  force_prev = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [CHW-1:0] out_ch;
    logic [1:0]     out_spike;
    logic [DW-1:0]  out_prev;
    logic [CW-1:0]  spike_cnt;

    typedef struct {
        int ch;
        int spike;
        int prv;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   m_prev[NC];
    int   m_cnt;
    bit   m_pending;
    int   total = 0;
    int   bad = 0;

    delta_mod_encoder_mc #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .threshold(threshold), .step_mode(step_mode),
        .off_spike(off_spike), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_data(in_data), .load_prev(load_prev), .load_ch(load_ch),
        .force_prev(force_prev), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_spike(out_spike), .out_prev(out_prev), .spike_cnt(spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the next rising edge should do, from the encoder's rules.
    task automatic modelStep();
        bit   rdy;
        bit   acc;
        bit   up;
        bit   dn;
        int   c;
        int   d;
        int   np;
        exp_t e;
        rdy = !m_pending || out_ready;
        checkOutput("in_ready", int'(in_ready), int'(rdy));
        checkOutput("out_valid", int'(out_valid), int'(m_pending));
        acc = in_valid && rdy;
        if (m_pending && out_ready) m_pending = 1'b0;
        c = int'(in_ch);
        if (acc && c < NC) begin
            d  = int'(in_data) - m_prev[c];
            up = (d > 0) && (d >= int'(threshold));
            dn = (d < 0) && (-d >= int'(threshold));
            np = m_prev[c];
            if (up || dn) begin
                if (!step_mode) np = int'(in_data);
                else if (up) np = (m_prev[c] + int'(threshold) > MAXV) ? MAXV : m_prev[c] + int'(threshold);
                else np = (m_prev[c] - int'(threshold) < 0) ? 0 : m_prev[c] - int'(threshold);
            end
            if (load_prev && int'(load_ch) == c) np = int'(force_prev);
            if (up || dn) m_cnt = (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
            if (up || dn || off_spike) begin
                e.ch    = c;
                e.spike = up ? 2 : (dn ? 1 : 0);
                e.prv   = np;
                e.cnt   = m_cnt;
                sb.push_back(e);
                m_pending = 1'b1;
            end
            m_prev[c] = np;
        end
        if (load_prev && int'(load_ch) < NC) m_prev[int'(load_ch)] = int'(force_prev);
    endtask

    task automatic applyStimulus(input int v, input int ch, input int data, input int thr,
                                 input int step, input int off, input int ordy,
                                 input int ld, input int ldch, input int frc);
        in_valid   = v[0];
        in_ch      = CHW'(ch);
        in_data    = DW'(data);
        threshold  = DW'(thr);
        step_mode  = step[0];
        off_spike  = off[0];
        out_ready  = ordy[0];
        load_prev  = ld[0];
        load_ch    = CHW'(ldch);
        force_prev = DW'(frc);
        #1;
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        load_prev = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        for (int i = 0; i < NC; i++) m_prev[i] = 0;
        m_cnt     = 0;
        m_pending = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_spike_cnt", int'(spike_cnt), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_pending) && n < 20) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            n++;
        end
        checkOutput("drain_queue_empty", sb.size(), 0);
    endtask

    // Monitor: every handshake on the output side consumes one predicted event.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_event", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("out_ch", int'(out_ch), e.ch);
                checkOutput("out_spike", int'(out_spike), e.spike);
                checkOutput("out_prev", int'(out_prev), e.prv);
                checkOutput("spike_cnt", int'(spike_cnt), e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        doReset();
        // T1: diff 0 with off_spike low produces nothing
        applyStimulus(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        // T2: stepping up to saturation on channel 1
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 15, 3, 1, 0, 1, 0, 0, 0);
        drain();
        // T3: tracking mode, down spike then sub-threshold
        applyStimulus(0, 0, 0, 4, 0, 1, 1, 1, 2, 10);
        applyStimulus(1, 2, 5, 4, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 2, 3, 4, 0, 1, 1, 0, 0, 0);
        drain();
        // T4: alternate channels under backpressure
        for (int i = 0; i < 10; i++)
            applyStimulus(1, (i % 2) ? 3 : 0, $urandom_range(0, 15), 2, 0, 1,
                          (i >= 2 && i <= 4) ? 0 : 1, 0, 0, 0);
        drain();
        // T5: same-edge load and accept on channel 1
        applyStimulus(0, 0, 0, 2, 0, 1, 1, 1, 1, 0);
        applyStimulus(1, 1, 8, 2, 0, 1, 1, 1, 1, 12);
        applyStimulus(1, 1, 12, 2, 0, 1, 1, 0, 0, 0);
        drain();
        // T6: full throughput with counter saturation
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1, i % 4, 15, 1, 1, 0, 1, 0, 0, 0);
        drain();
        checkOutput("spike_cnt_saturated", int'(spike_cnt), MAXC);
        // Random traffic, including a mid-stream reset
        doReset();
        for (int i = 0; i < 300; i++) begin
            if (i == 150) doReset();
            applyStimulus(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 3),
                          $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1),
                          $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0,
                          ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 3),
                          $urandom_range(0, 15));
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
